// File: rtl/dpram_clear_ctrl.sv
// -----------------------------------------------------------------------------
// dpram_clear_ctrl
//
// Sequencer and port mux placed in front of one true dual-port RAM (single
// clock domain). On request, both RAM ports write zero to every entry, two
// entries per cycle. Outside a sweep, client ports A and B pass straight
// through to the RAM with no added latency.
//
// Parameters
//   ADDRLEN        address width, both ports
//   DATALEN        data width
//   DEPTH          number of entries, 2 <= DEPTH <= 2**ADDRLEN, odd allowed
//   CLEAR_ON_RESET 1: sweep starts automatically after reset, 0: idle
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   clear_req             start a sweep (level, sampled each cycle)
//   busy                  sweep in progress, client accesses blocked
//   done                  one-cycle pulse, cycle after the last sweep write
//   ca_* / cb_*           client ports A/B (addr, wdata, we, rdata)
//   ram_*a / ram_*b       RAM ports A/B (addr, wdata, we out; rdata in)
// -----------------------------------------------------------------------------
module dpram_clear_ctrl #(
  parameter int ADDRLEN        = 10,
  parameter int DATALEN        = 2,
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_req,
  output logic               busy,
  output logic               done,
  // client port A
  input  logic [ADDRLEN-1:0] ca_addr,
  input  logic [DATALEN-1:0] ca_wdata,
  input  logic               ca_we,
  output logic [DATALEN-1:0] ca_rdata,
  // client port B
  input  logic [ADDRLEN-1:0] cb_addr,
  input  logic [DATALEN-1:0] cb_wdata,
  input  logic               cb_we,
  output logic [DATALEN-1:0] cb_rdata,
  // RAM port A
  output logic [ADDRLEN-1:0] ram_addra,
  output logic [DATALEN-1:0] ram_wdataa,
  output logic               ram_wea,
  input  logic [DATALEN-1:0] ram_rdataa,
  // RAM port B
  output logic [ADDRLEN-1:0] ram_addrb,
  output logic [DATALEN-1:0] ram_wdatab,
  output logic               ram_web,
  input  logic [DATALEN-1:0] ram_rdatab
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Number of sweep beats (two entries per beat) and the count of beats in
  // which port B still points inside the array.
  localparam int          NB       = (DEPTH + 1) / 2;
  localparam int unsigned NB_FULL  = DEPTH / 2;
  localparam logic [ADDRLEN-1:0] K_LAST = ADDRLEN'(NB - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDRLEN-1:0] r_k;
  logic               r_rd_mask;

  logic               w_last;
  logic [ADDRLEN-1:0] w_sweep_addra;
  logic [ADDRLEN-1:0] w_sweep_addrb;
  logic               w_sweep_web;

  assign w_last        = (r_k == K_LAST);
  assign w_sweep_addra = r_k << 1;
  assign w_sweep_addrb = w_sweep_addra | ADDRLEN'(1);
  // 2k+1 < DEPTH reduces to k < floor(DEPTH/2); only false on the last beat
  // of an odd-depth sweep, where port B would point past the array.
  assign w_sweep_web   = (32'(r_k) < NB_FULL);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (clear_req) w_state_nxt = S_CLEAR;
      // clear_req is deliberately ignored here: no restart, nothing pending.
      S_CLEAR: if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = clear_req ? S_CLEAR : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat counter and read-data mask
  // ---------------------------------------------------------------------------
  // The counter advances only inside a sweep and sits at zero otherwise, so
  // any entry into CLEAR (request or reset) starts from address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k <= '0;
    end else if (r_state == S_CLEAR && !w_last) begin
      r_k <= r_k + ADDRLEN'(1);
    end else begin
      r_k <= '0;
    end
  end

  // Reads issued during a sweep return the RAM's pre-clear contents one cycle
  // later; masking with the delayed busy makes them read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_mask <= 1'b0;
    end else begin
      r_rd_mask <= busy;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs and port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = (r_state == S_CLEAR);
    done       = (r_state == S_DONE);

    ram_addra  = ca_addr;
    ram_wdataa = ca_wdata;
    ram_wea    = ca_we;
    ram_addrb  = cb_addr;
    ram_wdatab = cb_wdata;
    ram_web    = cb_we;

    // Client writes during a sweep are dropped, not queued.
    if (r_state == S_CLEAR) begin
      ram_addra  = w_sweep_addra;
      ram_wdataa = '0;
      ram_wea    = 1'b1;
      ram_addrb  = w_sweep_addrb;
      ram_wdatab = '0;
      ram_web    = w_sweep_web;
    end

    ca_rdata = r_rd_mask ? '0 : ram_rdataa;
    cb_rdata = r_rd_mask ? '0 : ram_rdatab;
  end

endmodule
